// File: rtl/collision_engine.sv
// Sequential pacman collision resolver: ghost/tile classification, dot/pill clearing and counters.
// Optional frightened-mode timer is built in when COLLISION_FRIGHT_EN is defined.
module collision_engine #(
    parameter int unsigned NUM_GHOSTS   = 2,
    parameter int unsigned X_W          = 6,
    parameter int unsigned Y_W          = 5,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned FRIGHT_TICKS = 360,
    localparam int unsigned GID_W       = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      load,
    input  logic [CNT_W-1:0]          init_dots,
    input  logic [CNT_W-1:0]          init_pills,
    input  logic                      start,
    input  logic [X_W-1:0]            next_pacman_x,
    input  logic [Y_W-1:0]            next_pacman_y,
    input  logic [NUM_GHOSTS*X_W-1:0] next_ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] next_ghost_y,
    input  logic                      frame_tick,
    output logic [Y_W+X_W-1:0]        map_addr,
    input  logic [1:0]                map_rdata,
    output logic                      map_we,
    output logic [1:0]                map_wdata,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                collision_type,
    output logic [GID_W-1:0]          ghost_id,
    output logic [CNT_W-1:0]          dots_left,
    output logic [CNT_W-1:0]          pills_left,
    output logic                      fright
);

    localparam logic [2:0] CT_NONE  = 3'd0;
    localparam logic [2:0] CT_WALL  = 3'd1;
    localparam logic [2:0] CT_DOT   = 3'd2;
    localparam logic [2:0] CT_PILL  = 3'd3;
    localparam logic [2:0] CT_GHOST = 3'd4;
    localparam logic [2:0] CT_EATEN = 3'd5;

    typedef enum logic [2:0] {IDLE, RD, EVAL, WR, DONE} state_t;

    state_t                    state, state_d;
    logic [X_W-1:0]            pac_x;
    logic [Y_W-1:0]            pac_y;
    logic [NUM_GHOSTS*X_W-1:0] ghost_x;
    logic [NUM_GHOSTS*Y_W-1:0] ghost_y;
    logic [2:0]                pend_type, pend_type_d;
    logic [GID_W-1:0]          pend_gid, pend_gid_d;
    logic [Y_W+X_W-1:0]        map_addr_d;
    logic                      map_we_d, busy_d, done_d;
    logic [2:0]                collision_type_d;
    logic [GID_W-1:0]          ghost_id_d;
    logic [CNT_W-1:0]          dots_d, pills_d;
    logic                      accept;
    logic                      ghost_hit;
    logic [GID_W-1:0]          hit_id;
    logic [2:0]                tile_type, eval_type;
    logic                      pill_reload;

    assign map_wdata   = 2'b00;
    assign accept      = (state == IDLE) && !load && start;
    assign pill_reload = (state == WR) && (pend_type == CT_PILL);

    // Ghost match: scan downwards so the lowest matching index is the one kept
    always_comb begin
        ghost_hit = 1'b0;
        hit_id    = '0;
        for (int i = int'(NUM_GHOSTS) - 1; i >= 0; i--) begin
            if (ghost_x[i*X_W +: X_W] == pac_x && ghost_y[i*Y_W +: Y_W] == pac_y) begin
                ghost_hit = 1'b1;
                hit_id    = GID_W'(i);
            end
        end
    end

    always_comb begin
        case (map_rdata)
            2'b01:   tile_type = CT_WALL;
            2'b10:   tile_type = CT_DOT;
            2'b11:   tile_type = CT_PILL;
            default: tile_type = CT_NONE;
        endcase
        eval_type = ghost_hit ? (fright ? CT_EATEN : CT_GHOST) : tile_type;
    end

    // Next-state and registered-output values
    always_comb begin
        state_d          = state;
        map_addr_d       = map_addr;
        map_we_d         = 1'b0;
        busy_d           = busy;
        done_d           = 1'b0;
        collision_type_d = collision_type;
        ghost_id_d       = ghost_id;
        dots_d           = dots_left;
        pills_d          = pills_left;
        pend_type_d      = pend_type;
        pend_gid_d       = pend_gid;

        case (state)
            IDLE: begin
                if (load) begin
                    dots_d  = init_dots;
                    pills_d = init_pills;
                end else if (start) begin
                    map_addr_d = {next_pacman_y, next_pacman_x};
                    busy_d     = 1'b1;
                    state_d    = RD;
                end
            end
            RD: state_d = EVAL;
            EVAL: begin
                pend_type_d = eval_type;
                pend_gid_d  = hit_id;
                if (eval_type == CT_DOT || eval_type == CT_PILL) begin
                    map_we_d = 1'b1;
                    state_d  = WR;
                end else begin
                    done_d           = 1'b1;
                    collision_type_d = eval_type;
                    ghost_id_d       = hit_id;
                    state_d          = DONE;
                end
            end
            WR: begin
                done_d           = 1'b1;
                collision_type_d = pend_type;
                ghost_id_d       = pend_gid;
                if (pend_type == CT_DOT && dots_left != '0)
                    dots_d = dots_left - CNT_W'(1);
                if (pend_type == CT_PILL && pills_left != '0)
                    pills_d = pills_left - CNT_W'(1);
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            map_addr       <= '0;
            map_we         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            collision_type <= CT_NONE;
            ghost_id       <= '0;
            dots_left      <= '0;
            pills_left     <= '0;
            pend_type      <= CT_NONE;
            pend_gid       <= '0;
        end else begin
            state          <= state_d;
            map_addr       <= map_addr_d;
            map_we         <= map_we_d;
            busy           <= busy_d;
            done           <= done_d;
            collision_type <= collision_type_d;
            ghost_id       <= ghost_id_d;
            dots_left      <= dots_d;
            pills_left     <= pills_d;
            pend_type      <= pend_type_d;
            pend_gid       <= pend_gid_d;
        end
    end

    // Request positions are captured once so the movement controller may move on
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pac_x   <= '0;
            pac_y   <= '0;
            ghost_x <= '0;
            ghost_y <= '0;
        end else if (accept) begin
            pac_x   <= next_pacman_x;
            pac_y   <= next_pacman_y;
            ghost_x <= next_ghost_x;
            ghost_y <= next_ghost_y;
        end
    end

`ifdef COLLISION_FRIGHT_EN
    localparam int unsigned FR_W = $clog2(FRIGHT_TICKS + 1);

    logic [FR_W-1:0] fr_cnt, fr_cnt_d;

    // Pill reload takes precedence over a coincident frame tick
    always_comb begin
        fr_cnt_d = fr_cnt;
        if (pill_reload)
            fr_cnt_d = FR_W'(FRIGHT_TICKS);
        else if (frame_tick && fr_cnt != '0)
            fr_cnt_d = fr_cnt - FR_W'(1);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fr_cnt <= '0;
            fright <= 1'b0;
        end else begin
            fr_cnt <= fr_cnt_d;
            fright <= (fr_cnt_d != '0);
        end
    end
`else
    logic unused_fright;

    assign fright        = 1'b0;
    assign unused_fright = frame_tick ^ pill_reload ^ (FRIGHT_TICKS == 0);
`endif

endmodule

// File: tb/tb_collision_engine.sv
// Self-checking bench for collision_engine: vector table, corner sequences and a randomized model run.
module tb_collision_engine;

    localparam int unsigned NG     = 2;
    localparam int unsigned XW     = 6;
    localparam int unsigned YW     = 5;
    localparam int unsigned CW     = 10;
    localparam int          FRIGHT = 360;
`ifdef COLLISION_FRIGHT_EN
    localparam bit FR_EN = 1'b1;
`else
    localparam bit FR_EN = 1'b0;
`endif

    localparam int T_NONE = 0, T_WALL = 1, T_DOT = 2, T_PILL = 3, T_GHOST = 4, T_EATEN = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [CW-1:0]     init_dots, init_pills;
    logic              start;
    logic [XW-1:0]     next_pacman_x;
    logic [YW-1:0]     next_pacman_y;
    logic [NG*XW-1:0]  next_ghost_x;
    logic [NG*YW-1:0]  next_ghost_y;
    logic              frame_tick;
    logic [YW+XW-1:0]  map_addr;
    logic [1:0]        map_rdata;
    logic              map_we;
    logic [1:0]        map_wdata;
    logic              busy, done;
    logic [2:0]        collision_type;
    logic [0:0]        ghost_id;
    logic [CW-1:0]     dots_left, pills_left;
    logic              fright;

    collision_engine #(
        .NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .CNT_W(CW), .FRIGHT_TICKS(FRIGHT)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .load(load), .init_dots(init_dots),
        .init_pills(init_pills), .start(start), .next_pacman_x(next_pacman_x),
        .next_pacman_y(next_pacman_y), .next_ghost_x(next_ghost_x),
        .next_ghost_y(next_ghost_y), .frame_tick(frame_tick), .map_addr(map_addr),
        .map_rdata(map_rdata), .map_we(map_we), .map_wdata(map_wdata), .busy(busy),
        .done(done), .collision_type(collision_type), .ghost_id(ghost_id),
        .dots_left(dots_left), .pills_left(pills_left), .fright(fright)
    );

    always #5 clk = ~clk;

    // Tile RAM environment: one-cycle read latency, write on map_we, bench preload port
    logic [1:0]  mem [0:2047];
    logic        pre_en;
    logic [10:0] pre_addr;
    logic [1:0]  pre_val;

    always @(posedge clk) begin
        map_rdata <= mem[map_addr];
        if (map_we) mem[map_addr] <= map_wdata;
        if (pre_en) mem[pre_addr] <= pre_val;
    end

    typedef struct {
        int px, py, g0x, g0y, g1x, g1y;
        int preset, tile;
        int typ, gid, cyc, we, dots, pills;
    } vec_t;

    vec_t tv [8];
    int   n_checks, n_fail;
    int   m_dots, m_pills, m_fr;
    int   ref_map [0:31][0:63];
    int   rpx, rpy, rg0x, rg0y, rg1x, rg1y, hit, et, eg, ec, ew, t, cnt;
    bit   found;

    function automatic logic [10:0] addr_of(input int x, input int y);
        return 11'(y * 64 + x);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic preset(input int x, input int y, input int v);
        @(negedge clk);
        pre_addr = addr_of(x, y);
        pre_val  = 2'(v);
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (m_fr > 0) m_fr--;
        end
    endtask

    // One request; returns at the negedge of the done cycle (or after a bounded wait)
    task automatic req(input string tag, input int px, input int py, input int g0x, input int g0y,
                       input int g1x, input int g1y, input bit disturb,
                       input int e_type, input int e_gid, input int e_cyc, input int e_we,
                       input int e_dots, input int e_pills, input int e_fr);
        int cyc, we_n, bad;
        cyc = 0; we_n = 0; bad = 0;
        @(negedge clk);
        next_pacman_x = 6'(px);
        next_pacman_y = 5'(py);
        next_ghost_x  = {6'(g1x), 6'(g0x)};
        next_ghost_y  = {5'(g1y), 5'(g0y)};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (disturb && k == 1) begin
                start = 1'b1; load = 1'b1;
                init_dots = 10'(99); init_pills = 10'(99);
                next_pacman_x = 6'(px + 1);
                next_pacman_y = 5'(py + 1);
            end
            if (disturb && k == 3) begin
                start = 1'b0; load = 1'b0;
            end
            if (map_we) we_n++;
            if (map_addr != addr_of(px, py) || map_wdata != 2'b00) bad++;
            if (done) begin
                cyc = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, " type"},  int'(collision_type), e_type);
        check({tag, " gid"},   int'(ghost_id), e_gid);
        check({tag, " cycle"}, cyc, e_cyc);
        check({tag, " we"},    we_n, e_we);
        check({tag, " addr"},  bad, 0);
        check({tag, " dots"},  int'(dots_left), e_dots);
        check({tag, " pills"}, int'(pills_left), e_pills);
        check({tag, " fright"}, int'(fright), e_fr);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; load = 1'b0; start = 1'b0; frame_tick = 1'b0; pre_en = 1'b0;
        pre_addr = '0; pre_val = '0; init_dots = '0; init_pills = '0;
        next_pacman_x = '0; next_pacman_y = '0; next_ghost_x = '0; next_ghost_y = '0;
        m_fr = 0;

        //        px  py g0x g0y g1x g1y pre tile    type     gid cyc we dots pills
        tv[0] = '{3,  4, 63, 31, 62, 31, 1, T_DOT,  T_DOT,   0, 4, 1, 4, 2};
        tv[1] = '{0,  0, 63, 31, 62, 31, 1, T_WALL, T_WALL,  0, 3, 0, 4, 2};
        tv[2] = '{7,  7,  7,  7,  7,  7, 1, T_DOT,  T_GHOST, 0, 3, 0, 4, 2};
        tv[3] = '{10, 2, 63, 31, 10,  2, 1, T_NONE, T_GHOST, 1, 3, 0, 4, 2};
        tv[4] = '{5,  5,  5,  6,  6,  5, 1, T_WALL, T_WALL,  0, 3, 0, 4, 2};
        tv[5] = '{3,  4, 63, 31, 62, 31, 0, T_NONE, T_NONE,  0, 3, 0, 4, 2};
        tv[6] = '{20, 10, 63, 31, 62, 31, 1, T_PILL, T_PILL, 0, 4, 1, 4, 1};
        tv[7] = '{12, 3,  0,  0,  0,  0, 1, T_DOT,  T_DOT,   0, 4, 1, 3, 1};

        repeat (2) @(negedge clk);
        check("rst busy",  int'(busy), 0);
        check("rst done",  int'(done), 0);
        check("rst we",    int'(map_we), 0);
        check("rst addr",  int'(map_addr), 0);
        check("rst type",  int'(collision_type), 0);
        check("rst gid",   int'(ghost_id), 0);
        check("rst dots",  int'(dots_left), 0);
        check("rst pills", int'(pills_left), 0);
        check("rst fright", int'(fright), 0);
        check("rst wdata", int'(map_wdata), 0);
        reset = 1'b0;

        // load together with start: counters load, request ignored
        @(negedge clk);
        load = 1'b1; start = 1'b1; init_dots = 10'(5); init_pills = 10'(2);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("ldst busy",  int'(busy), 0);
        check("ldst dots",  int'(dots_left), 5);
        check("ldst pills", int'(pills_left), 2);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("ldst no request", cnt, 0);

        for (int i = 0; i < 8; i++) begin
            if (tv[i].preset != 0) preset(tv[i].px, tv[i].py, tv[i].tile);
            if (tv[i].typ == T_PILL) m_fr = FRIGHT;
            req($sformatf("vec%0d", i), tv[i].px, tv[i].py, tv[i].g0x, tv[i].g0y,
                tv[i].g1x, tv[i].g1y, 1'b0, tv[i].typ, tv[i].gid, tv[i].cyc, tv[i].we,
                tv[i].dots, tv[i].pills, (FR_EN && m_fr > 0) ? 1 : 0);
        end

        // Ghost 1 hit after the pill, then frightened timeout
        preset(9, 9, T_NONE);
        req("fright_hit", 9, 9, 1, 1, 9, 9, 1'b0, FR_EN ? T_EATEN : T_GHOST, 1, 3, 0,
            3, 1, FR_EN ? 1 : 0);
        tick(FRIGHT - 1);
        check("fright 359 ticks", int'(fright), FR_EN ? 1 : 0);
        tick(1);
        check("fright 360 ticks", int'(fright), 0);

        // start and load pulsed while busy are ignored
        preset(15, 15, T_DOT);
        preset(16, 16, T_DOT);
        req("busy_ign", 15, 15, 63, 31, 62, 31, 1'b1, T_DOT, 0, 4, 1, 2, 1, 0);
        @(negedge clk);
        check("busy_ign idle", int'(busy), 0);
        check("busy_ign dots", int'(dots_left), 2);
        check("busy_ign tile", int'(mem[addr_of(16, 16)]), T_DOT);

        // Saturating counters at zero
        @(negedge clk);
        load = 1'b1; init_dots = '0; init_pills = '0;
        @(negedge clk);
        load = 1'b0;
        preset(30, 20, T_DOT);
        preset(31, 20, T_PILL);
        req("sat_dot", 30, 20, 63, 31, 62, 31, 1'b0, T_DOT, 0, 4, 1, 0, 0, 0);
        m_fr = FRIGHT;
        req("sat_pill", 31, 20, 63, 31, 62, 31, 1'b0, T_PILL, 0, 4, 1, 0, 0, FR_EN ? 1 : 0);

        // Randomized requests in a small region against the reference model
        @(negedge clk);
        m_dots  = int'($urandom_range(0, 20));
        m_pills = int'($urandom_range(0, 3));
        load = 1'b1; init_dots = 10'(m_dots); init_pills = 10'(m_pills);
        @(negedge clk);
        load = 1'b0;
        for (int round = 0; round < 3; round++) begin
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++) begin
                    ref_map[y][x] = int'($urandom_range(0, 3));
                    preset(x, y, ref_map[y][x]);
                end
            for (int r = 0; r < 40; r++) begin
                rpx  = int'($urandom_range(0, 3)); rpy  = int'($urandom_range(0, 3));
                rg0x = int'($urandom_range(0, 3)); rg0y = int'($urandom_range(0, 3));
                rg1x = int'($urandom_range(0, 3)); rg1y = int'($urandom_range(0, 3));
                hit = -1;
                if (rg0x == rpx && rg0y == rpy) hit = 0;
                else if (rg1x == rpx && rg1y == rpy) hit = 1;
                if (hit >= 0) begin
                    et = (FR_EN && m_fr > 0) ? T_EATEN : T_GHOST;
                    eg = hit; ec = 3; ew = 0;
                end else begin
                    t  = ref_map[rpy][rpx];
                    et = t; eg = 0;
                    ec = (t >= 2) ? 4 : 3;
                    ew = (t >= 2) ? 1 : 0;
                    if (t == T_DOT) begin
                        if (m_dots > 0) m_dots--;
                        ref_map[rpy][rpx] = 0;
                    end
                    if (t == T_PILL) begin
                        if (m_pills > 0) m_pills--;
                        ref_map[rpy][rpx] = 0;
                        m_fr = FRIGHT;
                    end
                end
                req("rand", rpx, rpy, rg0x, rg0y, rg1x, rg1y, 1'b0, et, eg, ec, ew,
                    m_dots, m_pills, (FR_EN && m_fr > 0) ? 1 : 0);
                tick(int'($urandom_range(0, 2)));
            end
            @(negedge clk);
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++)
                    check($sformatf("rand map (%0d,%0d)", x, y), int'(mem[addr_of(x, y)]),
                          ref_map[y][x]);
        end

        // Reset asserted during WR aborts the request
        preset(40, 25, T_DOT);
        @(negedge clk);
        next_pacman_x = 6'(40); next_pacman_y = 5'(25);
        next_ghost_x = {6'(62), 6'(63)}; next_ghost_y = {5'(31), 5'(31)};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (map_we) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstwr we seen", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("rstwr we",    int'(map_we), 0);
        check("rstwr busy",  int'(busy), 0);
        check("rstwr done",  int'(done), 0);
        check("rstwr addr",  int'(map_addr), 0);
        check("rstwr type",  int'(collision_type), 0);
        check("rstwr gid",   int'(ghost_id), 0);
        check("rstwr dots",  int'(dots_left), 0);
        check("rstwr pills", int'(pills_left), 0);
        check("rstwr fright", int'(fright), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rstwr no done", cnt, 0);
        check("rstwr tile kept", int'(mem[addr_of(40, 25)]), T_DOT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_engine.md
# collision_engine

Sequential collision resolver for the Pac-Man game core, generalised to NUM_GHOSTS ghosts and a parametrised tile grid. For each movement request it checks the proposed pacman tile against every ghost and against the external tile-map RAM, classifies the collision, and clears eaten dots/pills from the map. It also maintains remaining dot/pill counters. It sits between the movement controller (which issues requests once per game step) and the maze tile RAM.

## Interface
Parameters:
- NUM_GHOSTS, 2, number of ghosts checked; must be at least 1.
- X_W, 6, tile x-coordinate width.
- Y_W, 5, tile y-coordinate width.
- CNT_W, 10, width of the dot and pill counters.
- FRIGHT_TICKS, 360, frame ticks of frightened mode after a pill.

Ports (GID_W = max(1, clog2(NUM_GHOSTS))):
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  loads init_dots/init_pills into the counters; honoured only in IDLE.
- init_dots  in  CNT_W  initial dot count.
- init_pills  in  CNT_W  initial pill count.
- start  in  1  request strobe; sampled only when busy=0.
- next_pacman_x  in  X_W  proposed pacman tile x.
- next_pacman_y  in  Y_W  proposed pacman tile y.
- next_ghost_x  in  NUM_GHOSTS*X_W  packed ghost x; ghost i at [i*X_W +: X_W].
- next_ghost_y  in  NUM_GHOSTS*Y_W  packed ghost y.
- frame_tick  in  1  one-cycle pulse per video frame.
- map_addr  out  Y_W+X_W  tile RAM address {y,x}.
- map_rdata  in  2  tile code: 00 empty, 01 wall, 10 dot, 11 pill; valid one cycle after map_addr.
- map_we  out  1  tile RAM write enable.
- map_wdata  out  2  always 00.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; result valid.
- collision_type  out  3  000 none, 001 wall, 010 dot, 011 pill, 100 ghost, 101 ghost eaten.
- ghost_id  out  GID_W  index of hit ghost; 0 when no ghost hit.
- dots_left  out  CNT_W  remaining dots.
- pills_left  out  CNT_W  remaining pills.
- fright  out  1  frightened mode active.

## Operation
- FSM states: IDLE, RD, EVAL, WR, DONE.
- IDLE: when load=1, load the counters and ignore start in that cycle. Otherwise, when start=1, latch all positions and go to RD.
- RD: drive map_addr={latched y, latched x}; go to EVAL.
- EVAL: map_rdata valid. Classification priority:
  - Ghost match on both x and y: lowest index wins. Type 100, or 101 if fright=1. Map is not written.
  - Otherwise by tile: 01 -> wall, 10 -> dot, 11 -> pill, 00 -> none.
  - Dot or pill go to WR; all other results go to DONE.
- WR: map_we=1, map_wdata=00, map_addr unchanged. Decrement the matching counter, saturating at 0. Go to DONE.
- DONE: done=1; go to IDLE. busy=0 only in IDLE.
- collision_type and ghost_id are registered on entry to DONE and held until the next DONE.
- start or load outside IDLE: ignored.
- Coordinates are not range-checked; addresses wrap at the field width.

## Timing
- Start sampled at edge 0. Then RD in cycle 1, EVAL in cycle 2, and either DONE in cycle 3 (no write) or WR in cycle 3 and DONE in cycle 4.
- Throughput: one request per 4 or 5 cycles; the next start is accepted in the cycle after done.
- map_we is high for exactly one cycle per dot/pill event.
- Counters change at the WR->DONE edge and are visible with done.
- Reset values: IDLE, busy=0, done=0, map_we=0, map_addr=0, collision_type=000, ghost_id=0, dots_left=0, pills_left=0, fright=0.
- Reset mid-request aborts immediately: map_we drops asynchronously and no counter changes.

## Configuration
- COLLISION_FRIGHT_EN defined:
  - A pill event reloads the fright counter with FRIGHT_TICKS and sets fright=1 at the WR->DONE edge; reload also applies while fright is already active.
  - Each frame_tick decrements the counter; fright=0 when it reaches 0.
  - When a pill reload and a frame_tick occur in the same cycle, the reload wins.
- COLLISION_FRIGHT_EN undefined: fright is tied to 0, frame_tick is ignored, and type 101 is never produced.

## Test plan
- Reset, load init_dots=5, init_pills=2; dot tile at (3,4), start -> done in cycle 4 with type 010, map_we one cycle at addr {4,3}, dots_left=4.
- Wall tile at (0,0), start -> done in cycle 3 with type 001, no map_we, counters unchanged.
- Ghosts 0 and 1 both at pacman tile (7,7), tile holds a dot -> type 100, ghost_id=0, no write, dots_left unchanged.
- With macro: eat a pill (pills_left 2->1, fright=1), then hit ghost 1 -> type 101, ghost_id=1. After 360 frame_ticks, fright=0. Without macro: same stimulus gives type 100.
- dots_left=0, eat dot -> stays 0. Start pulsed while busy -> ignored. load together with start in IDLE -> counters loaded, no request.
- Assert reset during WR -> map_we falls immediately, all outputs return to reset values, no done pulse.
